// File: rtl/adc_pkg.sv
// +-----------------------------------------------------------------------------
// | adc_pkg : shared types and constants for the ADC sample controller
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package adc_pkg;

  localparam int ADC_W           = 8;
  localparam int DEF_TIMEOUT_CYC = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    START     = 2'd2,
    CONVERT   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/adc_sample_ctrl.sv
// +-----------------------------------------------------------------------------
// | adc_sample_ctrl : periodic ADC start/capture with single-entry output register
// | Optional ADC_SAMPLE_CTRL_AVG_EN: deliver rounded mean of 4 conversions.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module adc_sample_ctrl
  import adc_pkg::*;
#(
  parameter int PERIOD_W    = 16,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                adc_start,
  input  logic                adc_eoc,
  input  logic [ADC_W-1:0]    adc_dout,
  output logic [ADC_W-1:0]    sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                timeout_err,
  input  logic                err_clr
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t              state;
  logic [PERIOD_W-1:0] period_cnt;
  logic [PERIOD_W-1:0] period_load;
  logic [TO_W-1:0]     to_cnt;
  logic                eoc_q;
  logic                eoc_rise;
  logic                capture;
  logic                timeout_hit;
  logic                go_start;
  logic                new_valid;
  logic [ADC_W-1:0]    new_data;

  assign period_load = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign eoc_rise    = adc_eoc & ~eoc_q;
  assign capture     = (state == CONVERT) && eoc_rise;
  // to_cnt equals (cycles since adc_start - 1), so the flag rises exactly
  // TIMEOUT_CYC cycles after the start pulse.
  assign timeout_hit = (state == CONVERT) && !eoc_rise &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign go_start    = enable && ((state == IDLE) ||
                       ((state == WAIT_TICK) && (period_cnt == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      adc_start  <= 1'b0;
      period_cnt <= '0;
      to_cnt     <= '0;
      eoc_q      <= 1'b0;
    end else begin
      eoc_q     <= adc_eoc;
      adc_start <= 1'b0;
      if (period_cnt != '0) period_cnt <= period_cnt - PERIOD_W'(1);
      if ((state == START) || (state == CONVERT)) to_cnt <= to_cnt + TO_W'(1);

      if (go_start) begin
        state      <= START;
        adc_start  <= 1'b1;
        period_cnt <= period_load;
        to_cnt     <= '0;
      end else begin
        case (state)
          WAIT_TICK: if (!enable) state <= IDLE;
          START:     state <= CONVERT;
          CONVERT:   if (capture || timeout_hit) state <= enable ? WAIT_TICK : IDLE;
          default:   ;
        endcase
      end
    end
  end

`ifdef ADC_SAMPLE_CTRL_AVG_EN
  logic [9:0]  acc;
  logic [1:0]  acc_cnt;
  logic [10:0] avg_round;

  assign avg_round = {1'b0, acc} + {3'b000, adc_dout} + 11'd2;
  assign new_valid = capture && (acc_cnt == 2'd3);
  assign new_data  = (avg_round[10:2] > 9'd255) ? 8'hFF : avg_round[9:2];

  // A partial sum never survives a timeout or loss of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (capture) begin
      if ((acc_cnt == 2'd3) || !enable) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else begin
        acc     <= acc + {2'b00, adc_dout};
        acc_cnt <= acc_cnt + 2'd1;
      end
    end else if (timeout_hit || ((state == WAIT_TICK) && !enable)) begin
      acc     <= '0;
      acc_cnt <= '0;
    end
  end
`else
  assign new_valid = capture;
  assign new_data  = adc_dout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid <= 1'b0;
      sample_data  <= '0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (new_valid && (!sample_valid || sample_ready)) begin
        sample_valid <= 1'b1;
        sample_data  <= new_data;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (new_valid && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (err_clr)                                overrun <= 1'b0;

      if (timeout_hit)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

`default_nettype wire
